// File: rtl/jts16_cabio.sv
// jts16_cabio: System 16 cabinet I/O read port.
// Serves the cabinet region of the main CPU I/O map: system inputs, joysticks
// (standard, scanned multi-player or analog) and both DIP banks. The read data
// is registered one clock after the chip select is sampled.
// Optional build feature: define JTS16_COIN_LATCH_EN to turn the coin bits into
// sticky latches that remember short coin pulses until a system-port read.
module jts16_cabio #(
    parameter int PLAYERS = 2,
    parameter int ANACH   = 2
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   io_cs,
    input  logic [3:0]             addr,
    input  logic [1:0]             mode,
    input  logic                   ana_neg,
    input  logic [8*PLAYERS-1:0]   joystick,
    input  logic [16*ANACH-1:0]    joyana,
    input  logic [PLAYERS-1:0]     start_button,
    input  logic [1:0]             coin_input,
    input  logic                   service,
    input  logic                   dip_test,
    input  logic [7:0]             dipsw_a,
    input  logic [7:0]             dipsw_b,
    output logic [7:0]             dout,
    output logic [1:0]             scan_idx
);

    localparam logic [1:0] SCAN_MAX = 2'(PLAYERS - 1);
    localparam bit         MULTI    = (PLAYERS > 2);
    localparam bit         DUAL_ANA = (ANACH == 2);
    localparam logic [3:0] ADDR_SYS = 4'b0100;
    localparam logic [3:0] ADDR_P11 = 4'b0101;

    // Board wiring order of the joystick bits for standard/analog cabinets.
    function automatic logic [7:0] sort_joy(input logic [7:0] j);
        return {j[1:0], j[3:2], j[7], j[5:4], j[6]};
    endfunction

    // Board wiring order of the joystick bits on the scanned multi-player cabinet.
    function automatic logic [7:0] scan_joy(input logic [7:0] j);
        return {j[7:4], j[1:0], j[3:2]};
    endfunction

    // Analog byte: positive half as is, negative half as its two's complement.
    function automatic logic [7:0] ana_byte(input logic [15:0] a, input logic neg);
        logic [7:0] res;
        res = neg ? (~a[15:8] + 8'd1) : a[7:0];
        return res;
    endfunction

    logic       cs_last_r;
    logic       cs_rise_s;
    logic       cs_fall_s;
    logic [1:0] scan_r;
    logic [1:0] scan_nxt_s;
    logic [1:0] coin_s;
    logic [31:0] joy4_s;
    logic [31:0] ana2_s;
    logic [3:0]  start4_s;
    logic [7:0]  p1_sort_s;
    logic [7:0]  p2_sort_s;
    logic [7:0]  scan_sel_s;
    logic [7:0]  sys_s;
    logic [7:0]  rd_s;

    assign cs_rise_s = io_cs & ~cs_last_r;
    assign cs_fall_s = ~io_cs & cs_last_r;
    assign scan_idx  = scan_r;

`ifdef JTS16_COIN_LATCH_EN
    logic [1:0] coin_last_r;
    logic [1:0] coin_lat_r;
    logic [1:0] coin_pend_r;
    logic [1:0] coin_fall_s;
    logic       rd_sys_r;
    logic       sys_rise_s;
    logic       sys_act_s;
    logic       sys_clr_s;

    assign coin_fall_s = coin_last_r & ~coin_input;
    assign sys_rise_s  = cs_rise_s & (addr == ADDR_SYS);
    assign sys_act_s   = sys_rise_s | (rd_sys_r & io_cs);
    assign sys_clr_s   = rd_sys_r & cs_fall_s;
    assign coin_s      = ~coin_lat_r;

    // Sticky coin latches; edges seen during a system read are kept past its clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coin_last_r <= 2'b11;
            coin_lat_r  <= 2'b00;
            coin_pend_r <= 2'b00;
            rd_sys_r    <= 1'b0;
        end else begin
            coin_last_r <= coin_input;
            if (sys_clr_s) begin
                coin_lat_r  <= coin_pend_r | coin_fall_s;
                coin_pend_r <= 2'b00;
                rd_sys_r    <= 1'b0;
            end else begin
                coin_lat_r  <= coin_lat_r | coin_fall_s;
                coin_pend_r <= sys_act_s ? (coin_pend_r | coin_fall_s) : coin_pend_r;
                rd_sys_r    <= sys_rise_s ? 1'b1 : rd_sys_r;
            end
        end
    end
`else
    assign coin_s = coin_input;
`endif

    // Pad player/analog inputs to the maximum count; absent players read as released.
    always_comb begin
        joy4_s   = 32'hFFFF_FFFF;
        start4_s = 4'hF;
        ana2_s   = 32'h0000_0000;
        for (int i = 0; i < PLAYERS; i++) begin
            joy4_s[8*i +: 8] = joystick[8*i +: 8];
            start4_s[i]      = start_button[i];
        end
        for (int k = 0; k < ANACH; k++) begin
            ana2_s[16*k +: 16] = joyana[16*k +: 16];
        end
    end

    // Scan counter update: clear on a system read, step on a scanned player read.
    always_comb begin
        scan_nxt_s = scan_r;
        if (cs_rise_s && (addr == ADDR_SYS)) begin
            scan_nxt_s = 2'd0;
        end else if (cs_rise_s && (addr == ADDR_P11) && (mode == 2'd1)) begin
            scan_nxt_s = (scan_r == SCAN_MAX) ? 2'd0 : scan_r + 2'd1;
        end else begin
            scan_nxt_s = scan_r;
        end
    end

    // Read data mux; the player lookup uses the already-updated scan counter.
    always_comb begin
        p1_sort_s = sort_joy(joy4_s[7:0]);
        p2_sort_s = sort_joy(joy4_s[15:8]);
        case (scan_nxt_s)
            2'd0:    scan_sel_s = scan_joy(joy4_s[7:0]);
            2'd1:    scan_sel_s = scan_joy(joy4_s[15:8]);
            2'd2:    scan_sel_s = scan_joy(joy4_s[23:16]);
            2'd3:    scan_sel_s = scan_joy(joy4_s[31:24]);
            default: scan_sel_s = 8'hFF;
        endcase
        sys_s = {2'b11, start4_s[1:0], service, dip_test, coin_s};
        if (MULTI && (mode == 2'd1)) begin
            sys_s[7:6] = start4_s[3:2];
        end else begin
            sys_s[7:6] = 2'b11;
        end
        rd_s = 8'hFF;
        case (addr[3:2])
            2'd0: rd_s = 8'hFF;
            2'd1: begin
                case (addr[1:0])
                    2'd0: rd_s = sys_s;
                    2'd1: begin
                        case (mode)
                            2'd1:    rd_s = scan_sel_s;
                            2'd2:    rd_s = ana_byte(ana2_s[15:0], ana_neg);
                            default: rd_s = p1_sort_s;
                        endcase
                    end
                    2'd2:    rd_s = (mode == 2'd2) ? {p2_sort_s[7:4], p1_sort_s[7:4]} : 8'hFF;
                    2'd3:    rd_s = (DUAL_ANA && (mode == 2'd2)) ?
                                    ana_byte(ana2_s[31:16], ana_neg) : p2_sort_s;
                    default: rd_s = 8'hFF;
                endcase
            end
            2'd2:    rd_s = addr[0] ? dipsw_b : dipsw_a;
            default: rd_s = 8'hFF;
        endcase
    end

    // Chip-select history, scan counter and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_last_r <= 1'b0;
            scan_r    <= 2'd0;
            dout      <= 8'hFF;
        end else begin
            cs_last_r <= io_cs;
            scan_r    <= scan_nxt_s;
            dout      <= io_cs ? rd_s : 8'hFF;
        end
    end

endmodule

// File: tb/tb_jts16_cabio.sv
// tb_jts16_cabio: directed bench for jts16_cabio (4 players, 2 analog channels).
// Coin expectations follow the JTS16_COIN_LATCH_EN build setting.
module tb_jts16_cabio;

    logic        clk;
    logic        rst_n;
    logic        io_cs;
    logic [3:0]  addr;
    logic [1:0]  mode;
    logic        ana_neg;
    logic [31:0] joystick;
    logic [31:0] joyana;
    logic [3:0]  start_button;
    logic [1:0]  coin_input;
    logic        service;
    logic        dip_test;
    logic [7:0]  dipsw_a;
    logic [7:0]  dipsw_b;
    logic [7:0]  dout;
    logic [1:0]  scan_idx;

    int n_checks = 0;
    int n_fail   = 0;

    jts16_cabio #(.PLAYERS(4), .ANACH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_cs        (io_cs),
        .addr         (addr),
        .mode         (mode),
        .ana_neg      (ana_neg),
        .joystick     (joystick),
        .joyana       (joyana),
        .start_button (start_button),
        .coin_input   (coin_input),
        .service      (service),
        .dip_test     (dip_test),
        .dipsw_a      (dipsw_a),
        .dipsw_b      (dipsw_b),
        .dout         (dout),
        .scan_idx     (scan_idx)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // One CPU read: chip select high for 'hold' cycles, sampled at a falling edge.
    task automatic do_read(input logic [3:0] a, input int hold, output logic [7:0] val);
        @(negedge clk);
        io_cs = 1'b1;
        addr  = a;
        repeat (hold) @(negedge clk);
        val   = dout;
        io_cs = 1'b0;
    endtask

    logic [7:0] v;
    logic [7:0] scan_exp [5];
    logic [1:0] idx_exp  [5];
    logic [7:0] coin_exp;

    initial begin
        scan_exp[0] = 8'h28; scan_exp[1] = 8'h3C; scan_exp[2] = 8'h41;
        scan_exp[3] = 8'h14; scan_exp[4] = 8'h28;
        idx_exp[0] = 2'd1; idx_exp[1] = 2'd2; idx_exp[2] = 2'd3;
        idx_exp[3] = 2'd0; idx_exp[4] = 2'd1;

        rst_n        = 1'b0;
        io_cs        = 1'b0;
        addr         = 4'h0;
        mode         = 2'd0;
        ana_neg      = 1'b0;
        joystick     = {8'h44, 8'h33, 8'h22, 8'h11};
        joyana       = {16'h8020, 16'h0150};
        start_button = 4'hF;
        coin_input   = 2'b11;
        service      = 1'b1;
        dip_test     = 1'b1;
        dipsw_a      = 8'h3C;
        dipsw_b      = 8'hA5;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_dout", dout, 8'hFF);
        check("rst_scan", {6'd0, scan_idx}, 8'h00);
        rst_n = 1'b1;

        // DIP banks and unowned regions
        do_read(4'b1001, 1, v); check("dip_b", v, 8'hA5);
        @(negedge clk);          check("cs_low_ff", dout, 8'hFF);
        do_read(4'b1000, 1, v); check("dip_a", v, 8'h3C);
        do_read(4'b0000, 1, v); check("ppi_ff", v, 8'hFF);
        do_read(4'b1100, 1, v); check("region3_ff", v, 8'hFF);

        // Standard mode ports
        do_read(4'b0101, 1, v); check("m0_p11", v, 8'h42);
        do_read(4'b0111, 1, v); check("m0_p13", v, 8'h84);
        do_read(4'b0110, 1, v); check("m0_p12", v, 8'hFF);
        start_button = 4'b0110;
        service      = 1'b0;
        do_read(4'b0100, 1, v); check("m0_sys", v, 8'hE7);
        mode = 2'd1;
        do_read(4'b0100, 1, v); check("m1_sys", v, 8'h67);
        start_button = 4'hF;
        service      = 1'b1;

        // Scanned multi-player reads after a clear
        do_read(4'b0100, 1, v); check("m1_clr_scan", {6'd0, scan_idx}, 8'h00);
        for (int i = 0; i < 5; i++) begin
            do_read(4'b0101, 1, v);
            check($sformatf("scan_rd%0d", i), v, scan_exp[i]);
            check($sformatf("scan_idx%0d", i), {6'd0, scan_idx}, {6'd0, idx_exp[i]});
        end
        do_read(4'b0101, 3, v);
        check("hold_dout", v, 8'h3C);
        check("hold_idx", {6'd0, scan_idx}, 8'h02);

        // Analog mode
        mode = 2'd2;
        do_read(4'b0101, 1, v); check("ana_pos", v, 8'h50);
        ana_neg = 1'b1;
        do_read(4'b0101, 1, v); check("ana_neg1", v, 8'hFF);
        joyana[15:0] = 16'h0050;
        do_read(4'b0101, 1, v); check("ana_neg0", v, 8'h00);
        joyana[15:0] = 16'h8000;
        do_read(4'b0101, 1, v); check("ana_neg80", v, 8'h80);
        do_read(4'b0111, 1, v); check("ana2_neg", v, 8'h80);
        ana_neg = 1'b0;
        do_read(4'b0111, 1, v); check("ana2_pos", v, 8'h20);
        do_read(4'b0110, 1, v); check("m2_p12", v, 8'h84);

        // Asynchronous reset in the middle of a held read
        mode = 2'd1;
        do_read(4'b0100, 1, v);
        do_read(4'b0101, 1, v);
        @(negedge clk);
        io_cs = 1'b1;
        addr  = 4'b0101;
        @(negedge clk);
        check("pre_rst_dout", dout, 8'h3C);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dout", dout, 8'hFF);
        check("async_rst_scan", {6'd0, scan_idx}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_dout", dout, 8'h28);
        check("post_rst_scan", {6'd0, scan_idx}, 8'h01);
        io_cs = 1'b0;

        // Coin pulse between reads
        mode = 2'd0;
        do_read(4'b0100, 1, v); check("coin_idle", v, 8'hFF);
        @(negedge clk); coin_input[0] = 1'b0;
        @(negedge clk); coin_input[0] = 1'b1;
`ifdef JTS16_COIN_LATCH_EN
        coin_exp = 8'hFE;
`else
        coin_exp = 8'hFF;
`endif
        do_read(4'b0100, 1, v); check("coin_pulse", v, coin_exp);
        do_read(4'b0100, 1, v); check("coin_cleared", v, 8'hFF);

        // Coin pulse during a system read
        @(negedge clk);
        io_cs = 1'b1;
        addr  = 4'b0100;
        @(negedge clk); coin_input[0] = 1'b0;
        @(negedge clk); coin_input[0] = 1'b1;
        @(negedge clk); io_cs = 1'b0;
        do_read(4'b0100, 1, v); check("coin_in_read", v, coin_exp);
        do_read(4'b0100, 1, v); check("coin_in_read_clr", v, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jts16_cabio.md
JTS16_CABIO -- requirements
Module: jts16_cabio

Interface
REQ-001 SHALL have parameter PLAYERS, default 2, number of digital joystick channels (legal range 2..4).
REQ-002 SHALL have parameter ANACH, default 2, number of analog channels (legal range 1..2).
REQ-003 SHALL have these ports, one per line (name  direction  width  meaning):
- clk  in  1  system clock; only clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- io_cs  in  1  registered I/O-region chip select from main CPU decoder.
- addr  in  4  {A[13:12],A[2:1]} of CPU bus.
- mode  in  2  0=standard, 1=scanned multi-player, 2=analog.
- ana_neg  in  1  analog half select (PPI port B bit 2).
- joystick  in  8*PLAYERS  active-low joysticks, player 1 in LSBs.
- joyana  in  16*ANACH  analog pairs {neg[15:8],pos[7:0]}, channel 1 in LSBs.
- start_button  in  PLAYERS  active-low starts.
- coin_input  in  2  active-low coins.
- service, dip_test  in  1 each  active-low.
- dipsw_a, dipsw_b  in  8 each  DIP banks.
- dout  out  8  registered read data.
- scan_idx  out  2  current scan counter value.

Function
REQ-004 SHALL register dout; value valid 1 clk after io_cs and addr are sampled high/valid; dout=8'hFF whenever io_cs was low in the sampling cycle.
REQ-005 SHALL decode addr[3:2]: 0 -> 8'hFF (PPI region, not owned); 1 -> cabinet ports; 2 -> addr[0] ? dipsw_b : dipsw_a; 3 -> 8'hFF.
REQ-006 Port 1.0 (system) SHALL return {2'b11, start_button[1:0], service, dip_test, coin[1:0]}; if PLAYERS>2 and mode==1, bits[7:6]=start_button[3:2] (start_button[2] for PLAYERS==3, bit 7 = 1).
REQ-007 Port 1.1 SHALL return: mode 0 -> sorted P1; mode 1 -> scanned player (REQ-009); mode 2 -> analog channel 1 (REQ-010).
REQ-008 Port 1.3 SHALL return: mode 2 and ANACH==2 -> analog channel 2; otherwise sorted P2. Port 1.2 SHALL return {P2[7:4],P1[7:4]} sorted in mode 2, else 8'hFF.
REQ-009 Scan counter: 2 bits, range 0..PLAYERS-1; cleared on io_cs rising edge with port 1.0 addressed; incremented on io_cs rising edge with port 1.1 addressed in mode 1, wrapping PLAYERS-1 -> 0; port 1.1 returns player (counter value after update)+1 mapped so successive reads after a clear yield P2,P3..PN,P1, i.e. selection index = counter value, counter increment applied before lookup; held io_cs SHALL NOT re-increment.
REQ-010 Analog byte SHALL be ana_neg ? (~neg + 1) mod 256 : pos; neg=0 -> 8'h00; neg=8'h80 -> 8'h80.
REQ-011 Sort (mode 0/2) SHALL map j to {j[1:0],j[3:2],j[7],j[5:4],j[6]}; scan mode SHALL map j to {j[7:4],j[1:0],j[3:2]}.
REQ-012 Edge detection SHALL use a registered copy of io_cs; io_cs rising edge and addr change in same cycle SHALL use new addr.

Reset
REQ-013 While rst_n low: dout=8'hFF, scan counter=0, scan_idx=0, io_cs history=0, coin latches=0; release takes effect on first clk edge after deassertion.
REQ-014 Reset mid-read SHALL abort the read; next io_cs high after release counts as a rising edge.

Configuration
REQ-015 Macro JTS16_COIN_LATCH_EN: when defined, each coin bit SHALL be a sticky latch set on a coin_input falling edge (coin reported 0) and cleared on io_cs falling edge after a port 1.0 read; a coin edge during that same read SHALL survive the clear; when undefined, coin bits SHALL be raw coin_input and no latch flops exist.

Verification
REQ-016 Reset: rst_n=0 mid-read with io_cs=1 -> dout=8'hFF, scan_idx=0 immediately (asynchronous).
REQ-017 PLAYERS=4, mode=1: read 1.0, then five 1.1 reads with joystick={8'h44,8'h33,8'h22,8'h11} -> 1.1 bytes are scan-mapped 8'h22,8'h33,8'h44,8'h11,8'h22; scan_idx wraps 3->0.
REQ-018 mode=2, joyana1=16'h0150: ana_neg=0 -> 8'h50; ana_neg=1 -> 8'hFF; joyana1=16'h0050, ana_neg=1 -> 8'h00.
REQ-019 addr={2'b10,2'b01}, dipsw_b=8'hA5 -> dout=8'hA5 one clk after io_cs; io_cs=0 -> 8'hFF.
REQ-020 JTS16_COIN_LATCH_EN defined: 1-clk coin_input[0] low pulse -> next 1.0 read bit0=0, following read bit0=1; pulse during read -> bit0=0 on next read. Undefined: same pulse missed by later read (bit0=1).
